div_seq_param: RTL and testbench

- Parametrised multi-cycle integer divider; successor to the fixed 16-bit start/ready divider.
- Generalised in operand width, with an optional signed mode.
- Adds explicit divide-by-zero and overflow flags, a one-cycle done pulse, early completion on zero divisor, and an asynchronous reset.
- Sits beside the ALU as the shared divide unit; restoring radix-2, one quotient bit per clock.

---
 rtl/div_seq_param.sv | 163 ++++++++++++++++
 tb/tb_div_seq_param.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_param.sv
// Restoring radix-2 sequential divider: one quotient bit per clock.
// Unsigned or two's-complement (quotient truncated toward zero).
// Reports divide-by-zero and signed overflow, and pulses done when the result is ready.
module div_seq_param #(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             ready,
  output logic             done,
  output logic             div_zero,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q;       // dividend shifting out, quotient bits shifting in
  logic [WIDTH-1:0] acc_q;       // partial remainder
  logic [WIDTH-1:0] dvs_q;       // divisor magnitude
  logic [WIDTH-1:0] a_q;         // raw dividend, returned as remainder on b=0
  logic             negq_q;      // quotient needs negation
  logic             negr_q;      // remainder needs negation
  logic             zero_q;
  logic             ovfp_q;
  logic             fix_ph_q;    // 0: sign fix-up, 1: publish result
  logic [WIDTH-1:0] quot_s_q, rem_s_q;
  logic [WIDTH-1:0] quot_q, rem_q;
  logic             done_q, div_zero_q, ovf_q;

  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  logic             a_neg, b_neg, min_m1;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, trial;
  logic             ge;
  logic [WIDTH-1:0] acc_nxt, dvd_nxt, fq, fr;

  // Operand conditioning and one restoring-division step
  always_comb begin
    a_neg   = SIGNED && a[WIDTH-1];
    b_neg   = SIGNED && b[WIDTH-1];
    a_mag   = a_neg ? twos_neg(a) : a;
    b_mag   = b_neg ? twos_neg(b) : b;
    min_m1  = SIGNED && (a == MIN_V) && (b == '1);
    shifted = {acc_q, dvd_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    ge      = (shifted >= {1'b0, dvs_q});
    acc_nxt = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_nxt = {dvd_q[WIDTH-2:0], ge};
    if (zero_q) begin
      fq = '1;
      fr = a_q;
    end else begin
      fq = negq_q ? twos_neg(dvd_q) : dvd_q;
      fr = negr_q ? twos_neg(acc_q) : acc_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (b == '0) ? FIX : CALC;
      CALC: if (cnt_q == CW'(1)) state_d = FIX;
      FIX:  if (fix_ph_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    ready    = (state_q == IDLE);
    done     = done_q;
    quot     = quot_q;
    rem      = rem_q;
    div_zero = div_zero_q;
    ovf      = ovf_q;
  end

  // Datapath: latch on accept, iterate in CALC, fix signs then publish in FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      dvd_q      <= '0;
      acc_q      <= '0;
      dvs_q      <= '0;
      a_q        <= '0;
      negq_q     <= 1'b0;
      negr_q     <= 1'b0;
      zero_q     <= 1'b0;
      ovfp_q     <= 1'b0;
      fix_ph_q   <= 1'b0;
      quot_s_q   <= '0;
      rem_s_q    <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q        <= a;
            dvd_q      <= a_mag;
            dvs_q      <= b_mag;
            acc_q      <= '0;
            cnt_q      <= CW'(WIDTH);
            negq_q     <= a_neg ^ b_neg;
            negr_q     <= a_neg;
            zero_q     <= (b == '0);
            ovfp_q     <= min_m1;
            fix_ph_q   <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
          end
        end
        CALC: begin
          acc_q <= acc_nxt;
          dvd_q <= dvd_nxt;
          cnt_q <= cnt_q - CW'(1);
        end
        FIX: begin
          if (!fix_ph_q) begin
            quot_s_q <= fq;
            rem_s_q  <= fr;
            fix_ph_q <= 1'b1;
          end else begin
            quot_q     <= quot_s_q;
            rem_q      <= rem_s_q;
            div_zero_q <= zero_q;
            ovf_q      <= ovfp_q;
            done_q     <= 1'b1;
            fix_ph_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_param.sv
// Bench for div_seq_param: 16-bit unsigned, 16-bit signed and 8-bit unsigned
// instances, scoreboard-checked on every done pulse.
module tb_div_seq_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // inst 0: W16 unsigned, inst 1: W16 signed, inst 2: W8 unsigned
  logic [15:0] a0, b0, q0, r0;
  logic        st0, rd0, dn0, dz0, ov0;
  logic [15:0] a1, b1, q1, r1;
  logic        st1, rd1, dn1, dz1, ov1;
  logic [7:0]  a2, b2, q2, r2;
  logic        st2, rd2, dn2, dz2, ov2;

  div_seq_param #(.WIDTH(16), .SIGNED(1'b0)) u_u16 (
    .clk(clk), .rst_n(rst_n), .a(a0), .b(b0), .start(st0), .quot(q0), .rem(r0),
    .ready(rd0), .done(dn0), .div_zero(dz0), .ovf(ov0));
  div_seq_param #(.WIDTH(16), .SIGNED(1'b1)) u_s16 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .start(st1), .quot(q1), .rem(r1),
    .ready(rd1), .done(dn1), .div_zero(dz1), .ovf(ov1));
  div_seq_param #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (
    .clk(clk), .rst_n(rst_n), .a(a2), .b(b2), .start(st2), .quot(q2), .rem(r2),
    .ready(rd2), .done(dn2), .div_zero(dz2), .ovf(ov2));

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ov;
  } res_t;

  res_t sb0[$], sb1[$], sb2[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input int inst, input logic [15:0] av, input logic [15:0] bv);
    res_t t;
    logic [15:0] m;
    logic signed [15:0] sa, sb;
    m  = (inst == 2) ? 16'h00FF : 16'hFFFF;
    av = av & m;
    bv = bv & m;
    sa = av;
    sb = bv;
    t  = '0;
    if (bv == 16'd0) begin
      t.q = m; t.r = av; t.dz = 1'b1;
    end else if (inst == 1) begin
      if (av == 16'h8000 && bv == 16'hFFFF) begin
        t.q = 16'h8000; t.r = 16'h0000; t.ov = 1'b1;
      end else begin
        t.q = sa / sb; t.r = sa % sb;
      end
    end else begin
      t.q = av / bv; t.r = av % bv;
    end
    return t;
  endfunction

  function automatic logic rdy(input int inst);
    return (inst == 0) ? rd0 : (inst == 1) ? rd1 : rd2;
  endfunction

  function automatic logic dn(input int inst);
    return (inst == 0) ? dn0 : (inst == 1) ? dn1 : dn2;
  endfunction

  task automatic set_in(input int inst, input logic [15:0] av, input logic [15:0] bv, input logic s);
    case (inst)
      0: begin a0 = av; b0 = bv; st0 = s; end
      1: begin a1 = av; b1 = bv; st1 = s; end
      default: begin a2 = av[7:0]; b2 = bv[7:0]; st2 = s; end
    endcase
  endtask

  task automatic push(input int inst, input res_t e);
    case (inst)
      0: sb0.push_back(e);
      1: sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  // Issue one operation from a negedge, check latency and the done pulse shape
  task automatic op(input int inst, input logic [15:0] av, input logic [15:0] bv);
    int n;
    int lat;
    res_t e;
    n = 0;
    while (!rdy(inst) && n < 100) begin @(negedge clk); n++; end
    e = model(inst, av, bv);
    push(inst, e);
    set_in(inst, av, bv, 1'b1);
    @(posedge clk);
    n = 1;
    @(negedge clk);
    set_in(inst, av, bv, 1'b0);
    while (!rdy(inst) && n < 100) begin @(posedge clk); n++; @(negedge clk); end
    lat = e.dz ? 2 : ((inst == 2) ? 10 : 18);
    chk("latency", n - 1, lat);
    chk("done_pulse", dn(inst), 1'b1);
    @(negedge clk);
    chk("done_clear", dn(inst), 1'b0);
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    res_t e;
    if (rst_n && dn0) begin
      if (sb0.size() == 0) chk("u16_unexpected_done", 1, 0);
      else begin
        e = sb0.pop_front();
        chk("u16_quot", q0, e.q); chk("u16_rem", r0, e.r);
        chk("u16_dz", dz0, e.dz); chk("u16_ovf", ov0, 1'b0);
      end
    end
  end

  always @(negedge clk) begin
    res_t e;
    if (rst_n && dn1) begin
      if (sb1.size() == 0) chk("s16_unexpected_done", 1, 0);
      else begin
        e = sb1.pop_front();
        chk("s16_quot", q1, e.q); chk("s16_rem", r1, e.r);
        chk("s16_dz", dz1, e.dz); chk("s16_ovf", ov1, e.ov);
      end
    end
  end

  always @(negedge clk) begin
    res_t e;
    if (rst_n && dn2) begin
      if (sb2.size() == 0) chk("u8_unexpected_done", 1, 0);
      else begin
        e = sb2.pop_front();
        chk("u8_quot", {8'h00, q2}, e.q); chk("u8_rem", {8'h00, r2}, e.r);
        chk("u8_dz", dz2, e.dz); chk("u8_ovf", ov2, 1'b0);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int n;
    logic [15:0] ra, rb;
    rst_n = 1'b0;
    set_in(0, 16'd0, 16'd0, 1'b0);
    set_in(1, 16'd0, 16'd0, 1'b0);
    set_in(2, 16'd0, 16'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_ready", rd0, 1'b1);
    chk("rst_quot", q0, 16'd0);
    chk("rst_rem", r0, 16'd0);
    chk("rst_done", dn0, 1'b0);
    chk("rst_dz", dz0, 1'b0);
    chk("rst_ovf", ov1, 1'b0);
    chk("rst_ready_u8", rd2, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    op(0, 16'd1000, 16'd7);
    op(0, 16'h1234, 16'd0);
    op(1, 16'hFFF9, 16'd2);
    op(1, 16'h8000, 16'hFFFF);
    op(1, 16'd7, 16'hFFFE);
    op(1, 16'hFFF8, 16'd0);
    op(2, 16'd200, 16'd3);

    // Start during busy is ignored, then start held high is accepted back-to-back
    set_in(0, 16'd50000, 16'd3, 1'b1);
    push(0, model(0, 16'd50000, 16'd3));
    @(posedge clk);
    @(negedge clk);
    set_in(0, 16'd50000, 16'd3, 1'b0);
    repeat (4) @(negedge clk);
    set_in(0, 16'd9, 16'd4, 1'b1);
    @(negedge clk);
    set_in(0, 16'd9, 16'd4, 1'b0);
    @(negedge clk);
    set_in(0, 16'd9, 16'd4, 1'b1);
    push(0, model(0, 16'd9, 16'd4));
    n = 0;
    while (!dn0 && n < 100) begin @(negedge clk); n++; end
    chk("b2b_first_done", dn0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_accepted", rd0, 1'b0);
    set_in(0, 16'd9, 16'd4, 1'b0);
    n = 0;
    while (!rd0 && n < 100) begin @(negedge clk); n++; end
    chk("b2b_second_ready", rd0, 1'b1);
    @(negedge clk);

    // Reset mid-operation aborts without a done pulse
    set_in(0, 16'd500, 16'd9, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 16'd500, 16'd9, 1'b0);
    repeat (7) @(negedge clk);
    chk("abort_busy", rd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", rd0, 1'b1);
    chk("abort_quot", q0, 16'd0);
    chk("abort_rem", r0, 16'd0);
    chk("abort_done", dn0, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", dn0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    op(0, 16'd500, 16'd9);

    // Random unsigned 8-bit, 25% small divisors including zero
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(255));
      rb = ($urandom_range(3) == 0) ? 16'($urandom_range(3)) : 16'($urandom_range(255));
      op(2, ra, rb);
    end
    // Random 16-bit unsigned and signed
    for (int i = 0; i < 150; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(3) == 0) ? 16'($urandom_range(3)) : 16'($urandom);
      op(0, ra, rb);
      op(1, ra, ($urandom_range(7) == 0) ? 16'hFFFF : rb);
    end

    repeat (2) @(negedge clk);
    chk("sb_drained", sb0.size() + sb1.size() + sb2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
